counterupdn_dualedge_param: RTL and testbench

COUNTERUPDN_DUALEDGE_PARAM -- requirements
Module: counterupdn_dualedge_param

---
 rtl/counterupdn_dualedge_param.sv | 102 ++++++++++
 tb/tb_counterupdn_dualedge_param.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counterupdn_dualedge_param.sv
// Dual-edge up/down counter.
// Two N-bit registers share the count: cp advances on the rising edge of clk
// and cn advances on the falling edge. The visible count is their modular sum,
// so in both-edge mode q_counter steps once per clock edge, twice per period.
// Every register is cleared at once by rst_counter, without waiting for clk.
`timescale 1ns/1ps

module counterupdn_dualedge_param #(
  parameter int           N     = 12,
  parameter logic [N-1:0] MATCH = '0
) (
  input  logic         clk,
  input  logic         rst_counter,
  input  logic         en,
  input  logic         up_dn,
  input  logic [1:0]   mode,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q_counter,
  output logic         zero,
  output logic         hit
);

  typedef enum logic [1:0] {
    MODE_POS  = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] cp;
  logic [N-1:0] cn;
  logic [N-1:0] cp_step;
  logic [N-1:0] cn_step;
  logic         cp_count;
  logic         cn_count;
  mode_e        mode_sel;

  assign mode_sel = mode_e'(mode);

  // Decide which halves count on their edge, and the +/-1 value each would
  // take. Wrap in both directions falls out of N-bit modular arithmetic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    cp_count = 1'b0;
    cn_count = 1'b0;
    cp_step  = cp;
    cn_step  = cn;
    if (en) begin
      cp_count = (mode_sel == MODE_POS) || (mode_sel == MODE_BOTH);
      cn_count = (mode_sel == MODE_NEG) || (mode_sel == MODE_BOTH);
    end
    cp_step = up_dn ? (cp + ONE) : (cp - ONE);
    cn_step = up_dn ? (cn + ONE) : (cn - ONE);
  end

  // Rising-edge half: clear wins over load, and load wins over counting.
  always_ff @(posedge clk or posedge rst_counter) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the edge; blocking assignments
    // here would make the result depend on the order of the statements.
    if (rst_counter) begin
      cp <= '0;
    end else if (clr) begin
      cp <= '0;
    end else if (load) begin
      cp <= d;
    end else if (cp_count) begin
      cp <= cp_step;
    end
  end

  // Falling-edge half: a load zeroes cn, so that after a full period the
  // sum equals d.
  always_ff @(negedge clk or posedge rst_counter) begin
    if (rst_counter) begin
      cn <= '0;
    end else if (clr || load) begin
      cn <= '0;
    end else if (cn_count) begin
      cn <= cn_step;
    end
  end

  // Record the pre-edge sum compared against MATCH, one bit per rising edge.
  always_ff @(posedge clk or posedge rst_counter) begin
    if (rst_counter) begin
      hit <= 1'b0;
    end else begin
      hit <= (q_counter == MATCH);
    end
  end

  // The sum can glitch between edges; consumers must sample it on an edge.
  assign q_counter = cp + cn;
  assign zero      = (q_counter == '0);

endmodule

// File: tb/tb_counterupdn_dualedge_param.sv
// Directed bench for the dual-edge up/down counter (N = 12, MATCH = 3).
// Inputs change 1 ns after a falling edge. Outputs are sampled 1 ns after an
// edge, so that they are read well away from the edges that change them.
`timescale 1ns/1ps

module tb_counterupdn_dualedge_param;

  localparam int N = 12;

  logic         clk = 1'b0;
  logic         rst_counter = 1'b1;
  logic         en = 1'b0;
  logic         up_dn = 1'b0;
  logic [1:0]   mode = 2'b11;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] d = '0;
  logic [N-1:0] q_counter;
  logic         zero;
  logic         hit;

  int total = 0;
  int bad   = 0;

  counterupdn_dualedge_param #(.N(N), .MATCH(12'd3)) dut (
    .clk         (clk),
    .rst_counter (rst_counter),
    .en          (en),
    .up_dn       (up_dn),
    .mode        (mode),
    .clr         (clr),
    .load        (load),
    .d           (d),
    .q_counter   (q_counter),
    .zero        (zero),
    .hit         (hit)
  );

  always #5 clk = ~clk;

  // Rising edges fall at 5, 15, 25 ns. Falling edges fall at 10, 20, 30 ns.
  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic after_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic periods(input int n);
    for (int i = 0; i < n; i++) after_neg();
  endtask

  // Pulse the reset in the middle of a low phase and release it before the
  // next rising edge. Control inputs are returned to idle.
  task automatic do_reset();
    after_neg();
    rst_counter = 1'b1;
    en = 1'b0; clr = 1'b0; load = 1'b0; mode = 2'b11;
    #2;
    rst_counter = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (q_counter !== 12'h000) begin
      bad++;
      $display("FAIL reset_q: got %h expected 000", q_counter);
    end
    total++;
    if (zero !== 1'b1 || hit !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got zero=%b hit=%b expected zero=1 hit=0", zero, hit);
    end
    rst_counter = 1'b0;
  endtask

  task automatic test_count_up_both();
    do_reset();
    mode = 2'b10; up_dn = 1'b1; en = 1'b1;
    after_pos();
    total++;
    if (q_counter !== 12'h001) begin
      bad++;
      $display("FAIL both_first_pos: got %h expected 001", q_counter);
    end
    after_neg();
    total++;
    if (q_counter !== 12'h002) begin
      bad++;
      $display("FAIL both_first_neg: got %h expected 002", q_counter);
    end
    periods(7);
    total++;
    if (q_counter !== 12'd16 || zero !== 1'b0) begin
      bad++;
      $display("FAIL both_8_periods: got q=%h zero=%b expected q=010 zero=0", q_counter, zero);
    end
  endtask

  task automatic test_load_wrap();
    logic [N-1:0] exp_seq [4];
    exp_seq = '{12'hFFF, 12'h000, 12'h001, 12'h002};
    en = 1'b0; load = 1'b1; d = 12'hFFE;
    periods(1);
    total++;
    if (q_counter !== 12'hFFE) begin
      bad++;
      $display("FAIL load_value: got %h expected ffe", q_counter);
    end
    load = 1'b0; mode = 2'b10; up_dn = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) after_pos();
      else after_neg();
      total++;
      if (q_counter !== exp_seq[i] || zero !== (exp_seq[i] == 12'h000)) begin
        bad++;
        $display("FAIL wrap_step%0d: got q=%h zero=%b expected q=%h zero=%b",
                 i, q_counter, zero, exp_seq[i], (exp_seq[i] == 12'h000));
      end
    end
  endtask

  task automatic test_count_down_neg();
    do_reset();
    mode = 2'b01; up_dn = 1'b0; en = 1'b1;
    after_pos();
    total++;
    if (q_counter !== 12'h000) begin
      bad++;
      $display("FAIL neg_only_pos_idle: got %h expected 000", q_counter);
    end
    after_neg();
    total++;
    if (q_counter !== 12'hFFF) begin
      bad++;
      $display("FAIL neg_down_wrap: got %h expected fff", q_counter);
    end
    periods(2);
    total++;
    if (q_counter !== 12'hFFD) begin
      bad++;
      $display("FAIL neg_down_3: got %h expected ffd", q_counter);
    end
    mode = 2'b11;
    periods(5);
    total++;
    if (q_counter !== 12'hFFD) begin
      bad++;
      $display("FAIL hold_mode: got %h expected ffd", q_counter);
    end
  endtask

  task automatic test_clr_over_load();
    do_reset();
    mode = 2'b00; up_dn = 1'b1; en = 1'b1;
    periods(5);
    total++;
    if (q_counter !== 12'h005) begin
      bad++;
      $display("FAIL pos_only_5: got %h expected 005", q_counter);
    end
    clr = 1'b1; load = 1'b1; d = 12'h555;
    after_pos();
    total++;
    if (q_counter !== 12'h000) begin
      bad++;
      $display("FAIL clr_over_load_pos: got %h expected 000", q_counter);
    end
    after_neg();
    total++;
    if (q_counter !== 12'h000 || zero !== 1'b1) begin
      bad++;
      $display("FAIL clr_over_load: got q=%h zero=%b expected q=000 zero=1", q_counter, zero);
    end
    clr = 1'b0; load = 1'b0;
    periods(1);
    total++;
    if (q_counter !== 12'h001) begin
      bad++;
      $display("FAIL count_after_clr: got %h expected 001", q_counter);
    end
  endtask

  task automatic test_dir_change();
    do_reset();
    mode = 2'b10; up_dn = 1'b1; en = 1'b1;
    after_pos();
    up_dn = 1'b0;
    after_neg();
    total++;
    if (q_counter !== 12'h000) begin
      bad++;
      $display("FAIL dir_change_neg: got %h expected 000", q_counter);
    end
    after_pos();
    total++;
    if (q_counter !== 12'hFFF) begin
      bad++;
      $display("FAIL dir_change_pos: got %h expected fff", q_counter);
    end
  endtask

  // Reset is released between a rising and a falling edge, so the first
  // active edge is a falling one. This leaves the sum odd before each rising
  // edge, and so the count of 3 is seen at a rising edge.
  task automatic test_hit();
    logic [N-1:0] exp_q [6];
    logic         exp_h [6];
    exp_q = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6};
    exp_h = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    after_pos();
    rst_counter = 1'b1;
    clr = 1'b0; load = 1'b0; en = 1'b1; mode = 2'b10; up_dn = 1'b1;
    #2;
    rst_counter = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) after_neg();
      else after_pos();
      total++;
      if (q_counter !== exp_q[i] || hit !== exp_h[i]) begin
        bad++;
        $display("FAIL hit_step%0d: got q=%h hit=%b expected q=%h hit=%b",
                 i, q_counter, hit, exp_q[i], exp_h[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    load = 1'b1; d = 12'h003;
    periods(1);
    d = 12'h123;
    periods(1);
    total++;
    if (q_counter !== 12'h123 || hit !== 1'b1) begin
      bad++;
      $display("FAIL preload_123: got q=%h hit=%b expected q=123 hit=1", q_counter, hit);
    end
    load = 1'b0; en = 1'b1; mode = 2'b10; up_dn = 1'b1;
    #1;
    rst_counter = 1'b1;
    #1;
    total++;
    if (q_counter !== 12'h000 || hit !== 1'b0 || zero !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: got q=%h hit=%b zero=%b expected q=000 hit=0 zero=1",
               q_counter, hit, zero);
    end
    periods(1);
    total++;
    if (q_counter !== 12'h000) begin
      bad++;
      $display("FAIL reset_held: got %h expected 000", q_counter);
    end
    #1;
    rst_counter = 1'b0;
    after_pos();
    total++;
    if (q_counter !== 12'h001 || hit !== 1'b0) begin
      bad++;
      $display("FAIL resume_after_reset: got q=%h hit=%b expected q=001 hit=0", q_counter, hit);
    end
  endtask

  initial begin
    test_reset();
    test_count_up_both();
    test_load_wrap();
    test_count_down_neg();
    test_clr_over_load();
    test_dir_change();
    test_hit();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
